restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//  Sequential signed divider: the inverse of the Booth multiplier in the same datapath.
//  Takes WIDTH-bit two's-complement dividend and divisor.
//  Produces the truncated quotient and remainder, one restoring iteration per clock.
//  Start/done handshake; sits beside the multiplier in the ALU datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (two's complement)
// PORTS
//  clk          in   1      clock, rising-edge active
//  rst          in   1      asynchronous active-high reset
//  start        in   1      request; sampled only in IDLE
//  dividend_in  in   WIDTH  signed dividend, sampled with start
//  divisor_in   in   WIDTH  signed divisor, sampled with start
//  quotient     out  WIDTH  signed quotient, truncated toward zero
//  remainder    out  WIDTH  signed remainder, same sign as dividend (or zero)
//  busy         out  1      high from start acceptance until the done cycle
//  done         out  1      one-cycle pulse; results valid and held afterwards
//  dbz          out  1      divide-by-zero flag for the last operation
//  ovf          out  1      overflow flag: most-negative / -1
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; quotient, remainder = 0; busy, done, dbz, ovf = 0.
//  States: IDLE -> RUN -> FIX -> IDLE. All outputs are registered.
//  IDLE, start=1 at edge E0:
//   - Latch |dividend| into Q, |divisor| into M; record sign_q = sd^sv and sign_r = sd.
//   - Clear A (WIDTH+1 bits) and the iteration count; clear dbz and ovf; set busy=1.
//   - Go to RUN.
//   - If divisor_in==0 at E0 instead: quotient={WIDTH{1}}, remainder=dividend_in, dbz=1.
//     done=1 in the cycle after E0; busy stays 0; stay in IDLE.
//  RUN (WIDTH edges, E1..EWIDTH), each edge:
//   - Shift {A,Q} left 1; A = A - M.
//   - If A is negative (MSB=1): restore A += M and set Q[0]=0; else Q[0]=1.
//   - Count increments; after edge EWIDTH go to FIX.
//  FIX (edge EWIDTH+1):
//   - quotient = sign_q ? -Q : Q; remainder = sign_r ? -A : A.
//   - ovf = 1 iff the dividend is most-negative and the divisor is -1.
//     The quotient wraps to the most-negative value in that case.
//   - done=1 and busy=0 in the following cycle; return to IDLE.
//  Latency: done is high in the cycle after edge E(WIDTH+1), i.e. WIDTH+2 edges
//  counting E0 (10 for WIDTH=8).
//  done is exactly one cycle wide. quotient, remainder, dbz and ovf hold until the
//  next accepted start.
//  Arithmetic widths:
//   - Magnitudes are WIDTH-bit unsigned; |most-negative| = 2^(WIDTH-1) is representable.
//   - A is WIDTH+1 bits so the subtract sign is never lost.
//  start while busy (RUN/FIX) is ignored; operand changes during RUN have no effect.
//  start held high continuously: a new op is accepted in the first IDLE cycle after
//  done (back-to-back with no gap beyond the done cycle).
//  Reset asserted mid-RUN: the operation is abandoned and no done pulse is produced.
//  A start after reset release behaves normally.
// TESTING
//  100 / 7 -> quotient=14 (0x0E), remainder=2, done pulses after 10 edges
//   (busy high for 9 cycles).
//  -100 / 7 -> quotient=-14 (0xF2), remainder=-2 (0xFE); 100 / -7 -> quotient=0xF2,
//   remainder=2; -100 / -7 -> quotient=14, remainder=0xFE.
//  -128 / -1 -> quotient=0x80, remainder=0, ovf=1; -128 / 1 -> quotient=0x80, ovf=0.
//  55 / 0 -> dbz=1, quotient=0xFF, remainder=55, done in the next cycle, busy never high.
//  Pulse start=1 with 20/3 during RUN of 100/7 -> ignored, result 14 r 2.
//   A following 20/3 gives 6 r 2.
//  Assert rst at cycle 4 of RUN -> all outputs 0 immediately, no done.
//   A new 9/4 gives 2 r 1.

Source files
------------

// File: rtl/restoring_divider_if.sv
// Start/done handshake and result bundle for the sequential signed divider.
interface restoring_divider_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dbz;
  logic             ovf;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend_in, divisor_in,
    input  quotient, remainder, busy, done, dbz, ovf
  );

  // Divider side.
  modport slave (
    input  start, dividend_in, divisor_in,
    output quotient, remainder, busy, done, dbz, ovf
  );

endinterface

// File: rtl/restoring_divider.sv
// Sequential signed restoring divider: one quotient bit per clock on operand
// magnitudes, signs applied in a final fix-up cycle. Quotient truncates toward
// zero; remainder takes the sign of the dividend.
module restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  restoring_divider_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;          // partial remainder, one extra bit for the subtract sign
  logic [WIDTH-1:0] q_q, q_d;          // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] m_q, m_d;          // divisor magnitude
  logic [CntW-1:0]  count_q, count_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_pend_q, ovf_pend_d;

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   a_sub;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] most_neg;

  assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
  // Magnitudes are unsigned, so |most-negative| fits.
  assign dvd_mag  = bus.dividend_in[WIDTH-1] ? -bus.dividend_in : bus.dividend_in;
  assign dvs_mag  = bus.divisor_in[WIDTH-1]  ? -bus.divisor_in  : bus.divisor_in;
  assign a_shift  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign a_sub    = a_shift - {1'b0, m_q};

  // Next-state and datapath control for IDLE -> RUN -> FIX.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    count_d     = count_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor_in == '0) begin
            // Divide by zero completes immediately without entering RUN.
            quotient_d  = '1;
            remainder_d = bus.dividend_in;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            done_d      = 1'b1;
          end else begin
            a_d        = '0;
            q_d        = dvd_mag;
            m_d        = dvs_mag;
            count_d    = '0;
            neg_quot_d = bus.dividend_in[WIDTH-1] ^ bus.divisor_in[WIDTH-1];
            neg_rem_d  = bus.dividend_in[WIDTH-1];
            ovf_pend_d = (bus.dividend_in == most_neg) && (bus.divisor_in == '1);
            dbz_d      = 1'b0;
            ovf_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = StRun;
          end
        end
      end
      StRun: begin
        if (a_sub[WIDTH]) begin
          a_d = a_shift;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          a_d = a_sub;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        quotient_d  = neg_quot_q ? -q_q : q_q;
        remainder_d = neg_rem_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        ovf_d       = ovf_pend_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      count_q     <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      count_q     <= count_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (WIDTH = 8).
module tb_restoring_divider;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  restoring_divider_if #(.WIDTH(8)) bus ();

  restoring_divider #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one accepted edge; returns #1 after that edge.
  task automatic start_op(input logic [7:0] dvd, input logic [7:0] dvs);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = dvd;
    bus.divisor_in  = dvs;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Edges counted include the accepting edge; busy sampled at each negedge before done.
  task automatic wait_done(output int edges, output int busy_cyc, output bit ok);
    edges    = 1;
    busy_cyc = 0;
    ok       = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] q, input logic [7:0] r,
                         input logic d, input logic o);
    chk({tag, ".quotient"}, 32'(bus.quotient), 32'(q));
    chk({tag, ".remainder"}, 32'(bus.remainder), 32'(r));
    chk({tag, ".dbz"}, 32'(bus.dbz), 32'(d));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(o));
  endtask

  task automatic op(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                    input logic [7:0] q, input logic [7:0] r, input logic d, input logic o);
    int edges, busy_cyc;
    bit ok;
    start_op(dvd, dvs);
    wait_done(edges, busy_cyc, ok);
    chk({tag, ".done_seen"}, 32'(ok), 32'd1);
    chk_res(tag, q, r, d, o);
  endtask

  initial begin
    int  edges, busy_cyc;
    bit  ok;
    bit  seen;
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.quotient", 32'(bus.quotient), 32'h00);
    chk("rst.remainder", 32'(bus.remainder), 32'h00);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.dbz", 32'(bus.dbz), 32'd0);
    chk("rst.ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;

    // 100 / 7 with latency, busy width, one-cycle done and hold
    start_op(8'd100, 8'd7);
    wait_done(edges, busy_cyc, ok);
    chk("p100_7.done_seen", 32'(ok), 32'd1);
    chk("p100_7.edges", 32'(edges), 32'd10);
    chk("p100_7.busy_cycles", 32'(busy_cyc), 32'd9);
    chk("p100_7.busy_at_done", 32'(bus.busy), 32'd0);
    chk_res("p100_7", 8'h0E, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    chk("p100_7.done_width", 32'(bus.done), 32'd0);
    chk("p100_7.hold_q", 32'(bus.quotient), 32'h0E);
    chk("p100_7.hold_r", 32'(bus.remainder), 32'h02);

    // Sign combinations
    op("m100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0);
    op("p100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
    op("m100_m7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);

    // Most-negative boundaries
    op("m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    op("m128_p1", 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);

    // Divide by zero
    start_op(8'd55, 8'd0);
    wait_done(edges, busy_cyc, ok);
    chk("dbz.done_seen", 32'(ok), 32'd1);
    chk("dbz.edges", 32'(edges), 32'd1);
    chk("dbz.busy_cycles", 32'(busy_cyc), 32'd0);
    chk("dbz.busy", 32'(bus.busy), 32'd0);
    chk_res("dbz", 8'hFF, 8'h37, 1'b1, 1'b0);

    // Start during RUN is ignored
    start_op(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = 8'd20;
    bus.divisor_in  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges, busy_cyc, ok);
    chk("ignore.done_seen", 32'(ok), 32'd1);
    chk_res("ignore", 8'h0E, 8'h02, 1'b0, 1'b0);
    op("p20_3", 8'd20, 8'd3, 8'h06, 8'h02, 1'b0, 1'b0);

    // start held high: back-to-back acceptance right after done
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = 8'd6;
    bus.divisor_in  = 8'd4;
    @(posedge clk);
    wait_done(edges, busy_cyc, ok);
    chk("b2b1.done_seen", 32'(ok), 32'd1);
    chk_res("b2b1", 8'h01, 8'h02, 1'b0, 1'b0);
    bus.dividend_in = 8'hF9;
    bus.divisor_in  = 8'd2;
    wait_done(edges, busy_cyc, ok);
    bus.start = 1'b0;
    chk("b2b2.done_seen", 32'(ok), 32'd1);
    chk("b2b2.edges", 32'(edges), 32'd10);
    chk_res("b2b2", 8'hFD, 8'hFF, 1'b0, 1'b0);

    // Reset mid-RUN abandons the operation
    start_op(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.quotient", 32'(bus.quotient), 32'h00);
    chk("midrst.remainder", 32'(bus.remainder), 32'h00);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("midrst.no_activity", 32'(seen), 32'd0);
    start_op(8'd9, 8'd4);
    wait_done(edges, busy_cyc, ok);
    chk("p9_4.done_seen", 32'(ok), 32'd1);
    chk("p9_4.edges", 32'(edges), 32'd10);
    chk_res("p9_4", 8'h02, 8'h01, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
